// File: rtl/frame_scanout_if.sv
// Frame scanout bus: start/status, frame-buffer read port and the pixel stream.
// The scanout engine takes the master side.
interface frame_scanout_if;
  logic        start;
  logic [16:0] read_address;
  logic [23:0] q;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_sof;
  logic        pix_eol;
  logic        pix_eof;
  logic        busy;
  logic        frame_done;

  modport master (
    input  start, q, pix_ready,
    output read_address, pix_data, pix_valid, pix_sof, pix_eol, pix_eof, busy, frame_done
  );
  modport slave (
    output start, q, pix_ready,
    input  read_address, pix_data, pix_valid, pix_sof, pix_eol, pix_eof, busy, frame_done
  );
endinterface

// File: rtl/frame_scanout.sv
// Scans one H_PIX x V_PIX frame out of a 1-cycle-latency RAM into a 2-entry
// output FIFO with sof/eol/eof tags, credit-limited to FIFO + in-flight <= 2.
module frame_scanout #(
  parameter int H_PIX = 320,
  parameter int V_PIX = 320
) (
  input  logic            clk,
  input  logic            rst,
  frame_scanout_if.master bus
);
  localparam logic [8:0]  X_LAST = 9'(H_PIX - 1);
  localparam logic [16:0] A_LAST = 17'(H_PIX * V_PIX - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  typedef struct packed {
    logic [23:0] data;
    logic        sof;
    logic        eol;
    logic        eof;
  } pix_t;

  state_t      state;
  logic [16:0] addr;
  logic [8:0]  x, y;
  logic        inflight;
  logic [2:0]  inflight_flags;
  pix_t        fifo [2];
  pix_t        head;
  logic        rd_ptr, wr_ptr;
  logic [1:0]  cnt;
  logic        busy_q, done_q;
  logic        pop, issue;
  logic [2:0]  slots_used;

  // Credit counts the slot freed by this cycle's pop so a held-high ready
  // sustains one pixel per clock.
  assign pop        = (cnt != 2'd0) && bus.pix_ready;
  assign slots_used = 3'(cnt) - 3'(pop) + 3'(inflight);
  assign issue      = (state == FETCH) && (slots_used < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      addr           <= '0;
      x              <= '0;
      y              <= '0;
      inflight       <= 1'b0;
      inflight_flags <= '0;
      fifo[0]        <= '0;
      fifo[1]        <= '0;
      rd_ptr         <= 1'b0;
      wr_ptr         <= 1'b0;
      cnt            <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      inflight <= issue;
      if (inflight) begin
        fifo[wr_ptr] <= {bus.q, inflight_flags};
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(inflight) - 2'(pop);
      if (issue) inflight_flags <= {(x == 9'd0) && (y == 9'd0), x == X_LAST, addr == A_LAST};

      case (state)
        IDLE: if (bus.start) begin
          state  <= FETCH;
          addr   <= '0;
          x      <= '0;
          y      <= '0;
          busy_q <= 1'b1;
        end
        FETCH: if (issue) begin
          // The last address is held so read_address never runs past the frame.
          if (addr == A_LAST) state <= DRAIN;
          else begin
            addr <= addr + 17'd1;
            if (x == X_LAST) begin
              x <= '0;
              y <= y + 9'd1;
            end else x <= x + 9'd1;
          end
        end
        DRAIN: if (cnt == 2'd0 && !inflight) begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign head             = fifo[rd_ptr];
  assign bus.pix_valid    = cnt != 2'd0;
  assign bus.pix_data     = head.data;
  assign bus.pix_sof      = head.sof & bus.pix_valid;
  assign bus.pix_eol      = head.eol & bus.pix_valid;
  assign bus.pix_eof      = head.eof & bus.pix_valid;
  assign bus.read_address = addr;
  assign bus.busy         = busy_q;
  assign bus.frame_done   = done_q;
endmodule

// File: tb/tb_frame_scanout.sv
// Bench for frame_scanout: three geometries, RAM holding mem[a]=a, and a
// pixel-index reference model (pixel k carries data k and its frame-position flags).
module tb_frame_scanout;
  localparam int H = 64;
  localparam int V = 24;
  localparam int N = H * V;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  frame_scanout_if bus();
  frame_scanout_if bus_s();
  frame_scanout_if bus_1();

  frame_scanout #(.H_PIX(H), .V_PIX(V)) dut   (.clk(clk), .rst(rst), .bus(bus));
  frame_scanout #(.H_PIX(4), .V_PIX(2)) dut_s (.clk(clk), .rst(rst), .bus(bus_s));
  frame_scanout #(.H_PIX(1), .V_PIX(1)) dut_1 (.clk(clk), .rst(rst), .bus(bus_1));

  // Synchronous RAM models, contents mem[a] = a.
  always @(posedge clk) begin
    bus.q   <= 24'(bus.read_address);
    bus_s.q <= 24'(bus_s.read_address);
    bus_1.q <= 24'(bus_1.read_address);
  end

  // Expected {sof, eol, eof} of pixel k in raster order.
  function automatic logic [2:0] exp_flags(int k, int h, int n);
    return {k == 0, (k % h) == h - 1, k == n - 1};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.read_address, bus.pix_data, bus.pix_valid, bus.pix_sof, bus.pix_eol,
         bus.pix_eof, bus.busy, bus.frame_done} !== 47'd0)
      begin failures++; $display("FAIL reset_outputs got addr=%0d data=%0d valid=%b busy=%b done=%b want all 0",
        bus.read_address, bus.pix_data, bus.pix_valid, bus.busy, bus.frame_done); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full();
    int idx = 0, first = -1, last_acc = -1, done_cyc = -1, dones = 0;
    @(negedge clk); bus.pix_ready = 1'b1; bus.start = 1'b1;
    for (int c = 1; c < N + 20; c++) begin
      @(negedge clk); bus.start = 1'b0;
      if (c == 1) begin
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL full_busy got %b want 1", bus.busy); end
      end
      if (bus.pix_valid) begin
        if (first < 0) first = c;
        checks++;
        if (bus.pix_data !== 24'(idx) || {bus.pix_sof, bus.pix_eol, bus.pix_eof} !== exp_flags(idx, H, N))
          begin failures++; $display("FAIL full_pixel got data=%0d flags=%b want data=%0d flags=%b",
            bus.pix_data, {bus.pix_sof, bus.pix_eol, bus.pix_eof}, idx, exp_flags(idx, H, N)); end
        idx++; last_acc = c;
      end
      if (bus.frame_done) begin
        dones++; done_cyc = c; checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL full_busy_drop got %b want 0", bus.busy); end
      end
    end
    checks++;
    if (first != 3) begin failures++; $display("FAIL full_first_valid got cycle %0d want 3", first); end
    checks++;
    if (idx != N) begin failures++; $display("FAIL full_count got %0d want %0d", idx, N); end
    checks++;
    if (last_acc != N + 2) begin failures++; $display("FAIL full_throughput last pixel at %0d want %0d", last_acc, N + 2); end
    checks++;
    if (dones != 1 || done_cyc != last_acc + 2)
      begin failures++; $display("FAIL full_frame_done got count=%0d cycle=%0d want 1 at %0d", dones, done_cyc, last_acc + 2); end
  endtask

  task automatic test_stall_random();
    int idx = 0, dones = 0, c = 0;
    @(negedge clk); bus.pix_ready = 1'b0; bus.start = 1'b1;
    repeat (10) begin
      @(negedge clk); bus.start = 1'b0;
      checks++;
      if (bus.read_address > 17'd2) begin failures++; $display("FAIL stall_credit got addr=%0d want <=2", bus.read_address); end
    end
    checks++;
    if ({bus.read_address, bus.pix_valid, bus.pix_data} !== {17'd2, 1'b1, 24'd0})
      begin failures++; $display("FAIL stall_hold got addr=%0d valid=%b data=%0d want 2 1 0",
        bus.read_address, bus.pix_valid, bus.pix_data); end
    while (dones == 0 && c < 8 * N) begin
      bus.pix_ready = 1'($urandom_range(0, 1));
      checks++;
      if (int'(bus.read_address) > idx + 2)
        begin failures++; $display("FAIL random_credit got addr=%0d accepted=%0d", bus.read_address, idx); end
      if (bus.pix_valid) begin
        checks++;
        if (bus.pix_data !== 24'(idx) || {bus.pix_sof, bus.pix_eol, bus.pix_eof} !== exp_flags(idx, H, N))
          begin failures++; $display("FAIL random_pixel got data=%0d flags=%b want data=%0d flags=%b",
            bus.pix_data, {bus.pix_sof, bus.pix_eol, bus.pix_eof}, idx, exp_flags(idx, H, N)); end
        if (bus.pix_ready) idx++;
      end
      if (bus.frame_done) dones++;
      @(negedge clk); c++;
    end
    checks++;
    if (idx != N || dones != 1) begin failures++; $display("FAIL random_complete got pixels=%0d done=%0d want %0d 1", idx, dones, N); end
  endtask

  task automatic test_restart();
    int idx = 0, dones = 0, c = 0;
    @(negedge clk); bus.pix_ready = 1'b1; bus.start = 1'b1;
    while (dones == 0 && c < N + 50) begin
      @(negedge clk); c++;
      bus.start = (idx == 500);
      if (bus.pix_valid) begin
        checks++;
        if (bus.pix_data !== 24'(idx) || {bus.pix_sof, bus.pix_eol, bus.pix_eof} !== exp_flags(idx, H, N))
          begin failures++; $display("FAIL restart_pixel got data=%0d want %0d", bus.pix_data, idx); end
        idx++;
      end
      if (bus.frame_done) dones++;
    end
    bus.start = 1'b0;
    checks++;
    if (idx != N || dones != 1) begin failures++; $display("FAIL restart_complete got pixels=%0d done=%0d want %0d 1", idx, dones, N); end
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.pix_valid !== 1'b0 || bus.frame_done !== 1'b0)
        begin failures++; $display("FAIL restart_idle got busy=%b valid=%b done=%b want 0", bus.busy, bus.pix_valid, bus.frame_done); end
    end
  endtask

  task automatic test_reset_mid();
    int idx = 0, dones = 0, c = 0, first = -1;
    @(negedge clk); bus.pix_ready = 1'b1; bus.start = 1'b1;
    while (idx < 1000 && c < N) begin
      @(negedge clk); c++; bus.start = 1'b0;
      if (bus.pix_valid) idx++;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.read_address, bus.pix_data, bus.pix_valid, bus.pix_sof, bus.pix_eol,
         bus.pix_eof, bus.busy, bus.frame_done} !== 47'd0)
      begin failures++; $display("FAIL midreset_outputs got addr=%0d data=%0d valid=%b busy=%b done=%b want all 0",
        bus.read_address, bus.pix_data, bus.pix_valid, bus.busy, bus.frame_done); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); bus.start = 1'b1;
    idx = 0; c = 0;
    while (dones == 0 && c < N + 20) begin
      @(negedge clk); c++; bus.start = 1'b0;
      if (bus.pix_valid) begin
        if (first < 0) first = c;
        checks++;
        if (bus.pix_data !== 24'(idx) || {bus.pix_sof, bus.pix_eol, bus.pix_eof} !== exp_flags(idx, H, N))
          begin failures++; $display("FAIL midreset_pixel got data=%0d flags=%b want data=%0d flags=%b",
            bus.pix_data, {bus.pix_sof, bus.pix_eol, bus.pix_eof}, idx, exp_flags(idx, H, N)); end
        idx++;
      end
      if (bus.frame_done) dones++;
    end
    checks++;
    if (first != 3 || idx != N || dones != 1)
      begin failures++; $display("FAIL midreset_restart got first=%0d pixels=%0d done=%0d want 3 %0d 1", first, idx, dones, N); end
  endtask

  task automatic test_small();
    int idx = 0, last_acc = -1, done_cyc = -1, dones = 0;
    @(negedge clk); bus_s.pix_ready = 1'b1; bus_s.start = 1'b1;
    for (int c = 1; c < 20; c++) begin
      @(negedge clk); bus_s.start = 1'b0;
      if (bus_s.pix_valid) begin
        checks++;
        if (bus_s.pix_data !== 24'(idx) || {bus_s.pix_sof, bus_s.pix_eol, bus_s.pix_eof} !== exp_flags(idx, 4, 8))
          begin failures++; $display("FAIL small_pixel got data=%0d flags=%b want data=%0d flags=%b",
            bus_s.pix_data, {bus_s.pix_sof, bus_s.pix_eol, bus_s.pix_eof}, idx, exp_flags(idx, 4, 8)); end
        idx++; last_acc = c;
      end
      if (bus_s.frame_done) begin dones++; done_cyc = c; end
    end
    checks++;
    if (idx != 8 || dones != 1 || done_cyc != last_acc + 2)
      begin failures++; $display("FAIL small_frame got pixels=%0d done=%0d at %0d want 8 1 at %0d",
        idx, dones, done_cyc, last_acc + 2); end
  endtask

  task automatic test_single();
    int idx = 0, first = -1, done_cyc = -1, dones = 0;
    @(negedge clk); bus_1.pix_ready = 1'b1; bus_1.start = 1'b1;
    for (int c = 1; c < 12; c++) begin
      @(negedge clk); bus_1.start = 1'b0;
      if (bus_1.pix_valid) begin
        if (first < 0) first = c;
        checks++;
        if (bus_1.pix_data !== 24'd0 || {bus_1.pix_sof, bus_1.pix_eol, bus_1.pix_eof} !== 3'b111)
          begin failures++; $display("FAIL single_pixel got data=%0d flags=%b want 0 111",
            bus_1.pix_data, {bus_1.pix_sof, bus_1.pix_eol, bus_1.pix_eof}); end
        idx++;
      end
      if (bus_1.frame_done) begin dones++; done_cyc = c; end
    end
    checks++;
    if (idx != 1 || first != 3 || dones != 1 || done_cyc != 5)
      begin failures++; $display("FAIL single_frame got pixels=%0d first=%0d done=%0d at %0d want 1 3 1 at 5",
        idx, first, dones, done_cyc); end
  endtask

  initial begin
    bus.start = 1'b0;   bus.pix_ready = 1'b0;
    bus_s.start = 1'b0; bus_s.pix_ready = 1'b0;
    bus_1.start = 1'b0; bus_1.pix_ready = 1'b0;
    test_reset();
    test_full();
    test_stall_random();
    test_restart();
    test_reset_mid();
    test_small();
    test_single();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
